// File: rtl/rob_id_alloc_ctrl.sv
// ROB unique-ID allocator front end: round-robin alloc arbitration, free queue, alloc/free slot sharing.
// Optional macro ROB_FREE_BYPASS_EN: an empty queue lets an incoming free issue in the same cycle.
module rob_id_alloc_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int FREE_DEPTH = 4,
    parameter int FREE_BURST = 3,
    localparam int REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0]  req_orig_id,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [REQ_IDX_W-1:0]         rsp_idx,
    output logic [ID_WIDTH-1:0]          rsp_unique_id,
    output logic                         alloc_req,
    output logic [ID_WIDTH-1:0]          alloc_orig_id,
    input  logic                         alloc_gnt,
    input  logic [ID_WIDTH-1:0]          alloc_unique_id,
    input  logic                         alloc_full,
    input  logic                         free_in_valid,
    input  logic [ID_WIDTH-1:0]          free_in_id,
    output logic                         free_in_ready,
    output logic                         free_req,
    output logic [ID_WIDTH-1:0]          free_id,
    input  logic [ID_WIDTH-1:0]          free_restored_id,
    output logic                         free_rsp_valid,
    output logic [ID_WIDTH-1:0]          free_rsp_orig_id
);

    localparam int PTR_W    = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(FREE_BURST + 1);

    logic [REQ_IDX_W-1:0] rr_ptr;
    logic                 lock_vld;
    logic [REQ_IDX_W-1:0] lock_idx;
    logic [STARVE_W-1:0]  starve_cnt;
    logic [ID_WIDTH-1:0]  fifo_mem [FREE_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     fifo_cnt;

    logic                 alloc_pending;
    logic                 free_pending;
    logic                 fifo_empty;
    logic                 bypass_cand;
    logic                 bypass_use;
    logic                 free_slot;
    logic                 alloc_slot;
    logic                 starve_max;
    logic                 grant;
    logic                 push;
    logic                 pop;
    logic                 sel_found;
    logic [REQ_IDX_W-1:0] sel;
    logic [REQ_IDX_W-1:0] sel_next;

    assign fifo_empty    = (fifo_cnt == CNT_W'(0));
    assign free_in_ready = (fifo_cnt != CNT_W'(FREE_DEPTH));
    assign alloc_pending = (|req_valid) & ~alloc_full;
    assign starve_max    = (starve_cnt == STARVE_W'(FREE_BURST));

`ifdef ROB_FREE_BYPASS_EN
    assign bypass_cand = fifo_empty & free_in_valid;
`else
    assign bypass_cand = 1'b0;
`endif

    // Slot arbitration: frees win unless an alloc has waited through a full free burst.
    always_comb begin
        free_pending = ~fifo_empty | bypass_cand;
        free_slot    = ~rst & free_pending & ~(alloc_pending & starve_max);
        alloc_slot   = ~rst & ~free_slot & alloc_pending;
        bypass_use   = free_slot & bypass_cand;
        alloc_req    = alloc_slot;
        free_req     = free_slot;
        grant        = alloc_slot & alloc_gnt;
        push         = free_in_valid & free_in_ready & ~bypass_use;
        pop          = free_slot & ~bypass_use;
        if (bypass_use) begin
            free_id = free_in_id;
        end else begin
            free_id = fifo_mem[rd_ptr];
        end
    end

    // Requester selection: a locked requester keeps priority, else first valid from rr_ptr.
    always_comb begin
        sel       = rr_ptr;
        sel_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel       = REQ_IDX_W'(cand);
            end else begin
                sel_found = sel_found;
            end
        end
        if (lock_vld) begin
            sel = lock_idx;
        end else begin
            sel = sel;
        end
        if (sel == REQ_IDX_W'(NUM_REQ - 1)) begin
            sel_next = '0;
        end else begin
            sel_next = sel + REQ_IDX_W'(1);
        end
        alloc_orig_id = req_orig_id[int'(sel)*ID_WIDTH +: ID_WIDTH];
        req_ready     = '0;
        if (grant) begin
            req_ready[sel] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Arbitration state: round-robin pointer, lock and free-burst counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            lock_vld   <= 1'b0;
            lock_idx   <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant) begin
                rr_ptr   <= sel_next;
                lock_vld <= 1'b0;
            end else if (|req_valid) begin
                lock_vld <= 1'b1;
                lock_idx <= sel;
            end
            if (grant || !alloc_pending) begin
                starve_cnt <= '0;
            end else if (free_req && !starve_max) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    // Free queue pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Free queue storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= free_in_id;
        end
    end

    // Registered completions for alloc and free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid        <= 1'b0;
            rsp_idx          <= '0;
            rsp_unique_id    <= '0;
            free_rsp_valid   <= 1'b0;
            free_rsp_orig_id <= '0;
        end else begin
            rsp_valid      <= grant;
            free_rsp_valid <= free_req;
            if (grant) begin
                rsp_idx       <= sel;
                rsp_unique_id <= alloc_unique_id;
            end
            if (free_req) begin
                free_rsp_orig_id <= free_restored_id;
            end
        end
    end

endmodule

// File: tb/tb_rob_id_alloc_ctrl.sv
// Directed self-checking bench for rob_id_alloc_ctrl (default parameters).
module tb_rob_id_alloc_ctrl;

`ifdef ROB_FREE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_orig_id;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_idx;
    logic [3:0]  rsp_unique_id;
    logic        alloc_req;
    logic [3:0]  alloc_orig_id;
    logic        alloc_gnt;
    logic [3:0]  alloc_unique_id;
    logic        alloc_full;
    logic        free_in_valid;
    logic [3:0]  free_in_id;
    logic        free_in_ready;
    logic        free_req;
    logic [3:0]  free_id;
    logic [3:0]  free_restored_id;
    logic        free_rsp_valid;
    logic [3:0]  free_rsp_orig_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Allocator stand-in: the restored original ID is the freed unique ID xor 0xA.
    assign free_restored_id = free_id ^ 4'hA;

    rob_id_alloc_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_orig_id(req_orig_id), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_unique_id(rsp_unique_id),
        .alloc_req(alloc_req), .alloc_orig_id(alloc_orig_id), .alloc_gnt(alloc_gnt),
        .alloc_unique_id(alloc_unique_id), .alloc_full(alloc_full),
        .free_in_valid(free_in_valid), .free_in_id(free_in_id), .free_in_ready(free_in_ready),
        .free_req(free_req), .free_id(free_id), .free_restored_id(free_restored_id),
        .free_rsp_valid(free_rsp_valid), .free_rsp_orig_id(free_rsp_orig_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_orig_id = '0; alloc_gnt = 1'b0;
        alloc_unique_id = '0; alloc_full = 1'b0; free_in_valid = 1'b0; free_in_id = '0;
        repeat (2) @(posedge clk);

        // Reset state, with a request present to show outputs are forced low
        @(negedge clk);
        req_valid = 4'hF; alloc_gnt = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_alloc_req", 32'(alloc_req), 32'h0);
        chk("rst_free_req", 32'(free_req), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_idx", 32'(rsp_idx), 32'h0);
        chk("rst_rsp_uid", 32'(rsp_unique_id), 32'h0);
        chk("rst_free_rsp_valid", 32'(free_rsp_valid), 32'h0);
        chk("rst_free_rsp_orig", 32'(free_rsp_orig_id), 32'h0);
        rst = 1'b0; req_valid = '0; alloc_gnt = 1'b0;
        #1;
        chk("post_rst_free_in_ready", 32'(free_in_ready), 32'h1);

        // Requesters 0 and 2
        @(negedge clk);
        req_valid = 4'b0101; req_orig_id = 16'h0905; alloc_gnt = 1'b1; alloc_unique_id = 4'h3;
        #1;
        chk("t1_alloc_req", 32'(alloc_req), 32'h1);
        chk("t1_orig0", 32'(alloc_orig_id), 32'h5);
        chk("t1_ready0", 32'(req_ready), 32'h1);
        @(negedge clk);
        chk("t1_rsp_valid0", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_idx0", 32'(rsp_idx), 32'h0);
        chk("t1_rsp_uid0", 32'(rsp_unique_id), 32'h3);
        req_valid = 4'b0100; alloc_unique_id = 4'h7;
        #1;
        chk("t1_orig2", 32'(alloc_orig_id), 32'h9);
        chk("t1_ready2", 32'(req_ready), 32'h4);
        @(negedge clk);
        chk("t1_rsp_valid2", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_idx2", 32'(rsp_idx), 32'h2);
        chk("t1_rsp_uid2", 32'(rsp_unique_id), 32'h7);
        req_valid = '0;
        #1;
        chk("t1_idle_alloc_req", 32'(alloc_req), 32'h0);
        @(negedge clk);
        chk("t1_rsp_pulse", 32'(rsp_valid), 32'h0);

        // Mid-operation reset to restart the round-robin pointer at 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // All four requesters continuously valid
        req_orig_id = 16'h4321;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) chk("t2_rsp_idx", 32'(rsp_idx), 32'((k - 1) % 4));
            req_valid = 4'hF;
            #1;
            chk("t2_ready", 32'(req_ready), 32'(1 << (k % 4)));
            chk("t2_orig", 32'(alloc_orig_id), 32'((k % 4) + 1));
        end
        @(negedge clk);
        chk("t2_rsp_last", 32'(rsp_idx), 32'h0);
        req_valid = '0; alloc_gnt = 1'b0;

        // Fill the free queue while requester 1 waits with no grant
        @(negedge clk);
        req_valid = 4'b0010; req_orig_id = 16'h00B0; free_in_valid = 1'b1; free_in_id = 4'h1;
        #1;
        chk("fill_free_latency", 32'(free_req), 32'(BYP));
        chk("fill_alloc_req0", 32'(alloc_req), 32'(!BYP));
        chk("fill_ready_nognt", 32'(req_ready), 32'h0);
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            free_in_id = 4'(i + 1);
            #1;
            chk("fill_free_in_ready", 32'(free_in_ready), 32'h1);
        end
        @(negedge clk);
        free_in_valid = 1'b0;
        #1;
        chk("full_free_in_ready", 32'(free_in_ready), 32'h0);
        chk("full_alloc_req", 32'(alloc_req), 32'h1);
        chk("full_free_req", 32'(free_req), 32'h0);

        // Burst pattern: alloc, free x3, alloc, free
        @(negedge clk);
        alloc_gnt = 1'b1; alloc_unique_id = 4'hC;
        #1;
        chk("b_ready1", 32'(req_ready), 32'h2);
        @(negedge clk);
        chk("b_rsp_idx1", 32'(rsp_idx), 32'h1);
        chk("b_rsp_uid", 32'(rsp_unique_id), 32'hC);
        chk("b_free1", 32'(free_req), 32'h1);
        chk("b_free_id1", 32'(free_id), 32'h4);
        chk("b_alloc_off", 32'(alloc_req), 32'h0);
        @(negedge clk);
        chk("b_frsp_valid", 32'(free_rsp_valid), 32'h1);
        chk("b_frsp_orig1", 32'(free_rsp_orig_id), 32'hE);
        chk("b_free_id2", 32'(free_id), 32'h5);
        chk("b_free_in_ready", 32'(free_in_ready), 32'h1);
        @(negedge clk);
        chk("b_frsp_orig2", 32'(free_rsp_orig_id), 32'hF);
        chk("b_free_id3", 32'(free_id), 32'h6);
        @(negedge clk);
        chk("b_frsp_orig3", 32'(free_rsp_orig_id), 32'hC);
        chk("b_alloc_after_burst", 32'(alloc_req), 32'h1);
        chk("b_ready_after_burst", 32'(req_ready), 32'h2);
        chk("b_no_free", 32'(free_req), 32'h0);
        @(negedge clk);
        chk("b_rsp_valid2", 32'(rsp_valid), 32'h1);
        chk("b_frsp_gap", 32'(free_rsp_valid), 32'h0);
        req_valid = '0;
        #1;
        chk("b_free4", 32'(free_req), 32'h1);
        chk("b_free_id4", 32'(free_id), 32'h7);
        @(negedge clk);
        chk("b_frsp_orig4", 32'(free_rsp_orig_id), 32'hD);
        chk("b_drained", 32'(free_req), 32'h0);

        // Allocator full: frees flow back to back, requester 3 stays locked
        @(negedge clk);
        alloc_full = 1'b1; req_valid = 4'b1000; req_orig_id = 16'hE000;
        free_in_valid = 1'b1; free_in_id = 4'h8;
        #1;
        chk("af_alloc0", 32'(alloc_req), 32'h0);
        chk("af_free0", 32'(free_req), 32'(BYP));
        @(negedge clk);
        free_in_id = 4'h9;
        #1;
        chk("af_alloc1", 32'(alloc_req), 32'h0);
        chk("af_free1", 32'(free_req), 32'h1);
        chk("af_free_id1", 32'(free_id), 32'(8 + int'(BYP)));
        @(negedge clk);
        free_in_id = 4'hA;
        #1;
        chk("af_alloc2", 32'(alloc_req), 32'h0);
        chk("af_free2", 32'(free_req), 32'h1);
        chk("af_free_id2", 32'(free_id), 32'(9 + int'(BYP)));
        @(negedge clk);
        free_in_valid = 1'b0;
        #1;
        chk("af_alloc3", 32'(alloc_req), 32'h0);
        chk("af_free3", 32'(free_req), 32'(!BYP));
        @(negedge clk);
        alloc_full = 1'b0; req_valid = 4'b1100; req_orig_id = 16'hED00;
        #1;
        chk("af_lock_ready3", 32'(req_ready), 32'h8);
        chk("af_lock_orig", 32'(alloc_orig_id), 32'hE);
        @(negedge clk);
        chk("af_rsp_idx3", 32'(rsp_idx), 32'h3);
        req_valid = 4'b0100;
        #1;
        chk("af_ready2", 32'(req_ready), 32'h4);
        chk("af_orig2", 32'(alloc_orig_id), 32'hD);

        // Free latency from an empty queue
        @(negedge clk);
        chk("lat_rsp_idx2", 32'(rsp_idx), 32'h2);
        req_valid = '0; free_in_valid = 1'b1; free_in_id = 4'h6;
        #1;
        chk("lat_free_same", 32'(free_req), 32'(BYP));
`ifdef ROB_FREE_BYPASS_EN
        chk("lat_free_id_same", 32'(free_id), 32'h6);
`endif
        @(negedge clk);
        free_in_valid = 1'b0;
        #1;
        chk("lat_free_next", 32'(free_req), 32'(!BYP));
`ifndef ROB_FREE_BYPASS_EN
        chk("lat_free_id_next", 32'(free_id), 32'h6);
`endif
        @(negedge clk);
        chk("lat_frsp_valid", 32'(free_rsp_valid), 32'(!BYP));
        chk("lat_frsp_orig", 32'(free_rsp_orig_id), 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
